// File: rtl/fpdiv_iterative.sv
// fpdiv_iterative: restoring shift-subtract fixed-point divider, c = a / b, all in Qn.d.
// One quotient bit per cycle over n+d cycles, val/rdy handshake on both sides.
// Optional feature macro: FPDIV_SATURATE_EN clamps overflow and divide-by-zero results;
// without it the low n bits of the signed quotient wrap around.
module fpdiv_iterative #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c
);

  localparam int            W    = n + d;
  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam bit            SGN  = (sign != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic          recv_rdy_q, recv_rdy_d;
  logic          send_val_q, send_val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  bmag_q, bmag_d;
  logic          neg_q, neg_d;
  logic [n:0]    rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [n-1:0]  c_q, c_d;
`ifdef FPDIV_SATURATE_EN
  logic          azero_q, azero_d;
  logic          ovf;
  localparam logic [n-1:0] MAX_POS  = SGN ? {1'b0, {(n-1){1'b1}}} : {n{1'b1}};
  localparam logic [n-1:0] MOST_NEG = {1'b1, {(n-1){1'b0}}};
`endif

  logic [n-1:0]  a_mag;
  logic [n-1:0]  b_mag;
  logic [n+1:0]  rem_sh;
  logic          take;
  logic [W-1:0]  q_next;
  logic [n-1:0]  res_lo;
  logic [n-1:0]  c_final;

  // Datapath: operand magnitudes, one restoring step, and the final (possibly clamped) result.
  // The dividend register doubles as the quotient register: as dividend bits shift out of
  // the top, quotient bits shift in at the bottom, so after n+d steps it holds q.
  always_comb begin
    a_mag   = (SGN && a[n-1]) ? -a : a;
    b_mag   = (SGN && b[n-1]) ? -b : b;
    rem_sh  = {rem_q, dvd_q[W-1]};
    take    = (rem_sh >= {2'b00, bmag_q});
    q_next  = {dvd_q[W-2:0], take};
    res_lo  = neg_q ? -q_next[n-1:0] : q_next[n-1:0];
`ifdef FPDIV_SATURATE_EN
    ovf     = (|q_next[W-1:n])
            || (SGN && !neg_q && q_next[n-1])
            || (SGN && neg_q && q_next[n-1] && (|q_next[n-2:0]));
    if ((bmag_q == '0) && azero_q) begin
      c_final = '0;
    end else if ((bmag_q == '0) || ovf) begin
      c_final = neg_q ? MOST_NEG : MAX_POS;
    end else begin
      c_final = res_lo;
    end
`else
    c_final = res_lo;
`endif
  end

  // Next-state logic: accept in IDLE, iterate n+d steps in CALC, hold result in DONE.
  always_comb begin
    state_d    = state_q;
    recv_rdy_d = recv_rdy_q;
    send_val_d = send_val_q;
    cnt_d      = cnt_q;
    bmag_d     = bmag_q;
    neg_d      = neg_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    c_d        = c_q;
`ifdef FPDIV_SATURATE_EN
    azero_d    = azero_q;
`endif
    case (state_q)
      IDLE: begin
        if (recv_val) begin
          state_d    = CALC;
          recv_rdy_d = 1'b0;
          bmag_d     = b_mag;
          neg_d      = SGN & (a[n-1] ^ b[n-1]);
          rem_d      = '0;
          cnt_d      = '0;
          dvd_d      = {a_mag, {d{1'b0}}};
`ifdef FPDIV_SATURATE_EN
          azero_d    = (a == '0);
`endif
        end
      end
      CALC: begin
        rem_d = take ? (n+1)'(rem_sh - {2'b00, bmag_q}) : (n+1)'(rem_sh);
        dvd_d = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d    = DONE;
          send_val_d = 1'b1;
          c_d        = c_final;
        end
      end
      DONE: begin
        if (send_rdy) begin
          state_d    = IDLE;
          send_val_d = 1'b0;
          recv_rdy_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        recv_rdy_d = 1'b1;
        send_val_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
      cnt_q      <= '0;
      bmag_q     <= '0;
      neg_q      <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      c_q        <= '0;
`ifdef FPDIV_SATURATE_EN
      azero_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      recv_rdy_q <= recv_rdy_d;
      send_val_q <= send_val_d;
      cnt_q      <= cnt_d;
      bmag_q     <= bmag_d;
      neg_q      <= neg_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      c_q        <= c_d;
`ifdef FPDIV_SATURATE_EN
      azero_q    <= azero_d;
`endif
    end
  end

  assign recv_rdy = recv_rdy_q;
  assign send_val = send_val_q;
  assign c        = c_q;

endmodule
